// File: rtl/ids_parcel_latch.sv
// Decode-side parcel latch: sizes pre-fetch instructions (16/32-bit), acks them,
// and buffers sized entries in a 2-deep FIFO presented to execute via valid/ready.
`ifndef RV_SOFID_RANGE
`define RV_SOFID_RANGE 3:0
`endif

module ids_parcel_latch #(
    parameter bit C_RVC_EN = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    resetb_i,
    input  logic                    clk_en_i,
    input  logic                    pfu_dav_i,
    output logic                    pfu_ack_o,
    output logic [1:0]              pfu_ack_size_o,
    input  logic [`RV_SOFID_RANGE]  pfu_sofid_i,
    input  logic [31:0]             pfu_ins_i,
    input  logic                    pfu_ferr_i,
    input  logic [31:0]             pfu_pc_i,
    input  logic                    exs_pc_wr_i,
    output logic                    ids_valid_o,
    input  logic                    ids_ready_i,
    output logic [31:0]             ids_ins_o,
    output logic                    ids_rvc_o,
    output logic                    ids_ilgl_o,
    output logic                    ids_ferr_o,
    output logic [`RV_SOFID_RANGE]  ids_sofid_o,
    output logic [31:0]             ids_pc_o,
    output logic [31:0]             ids_pc_next_o
);

    typedef struct packed {
        logic [31:0]            ins;
        logic                   rvc;
        logic                   ilgl;
        logic                   ferr;
        logic [`RV_SOFID_RANGE] sofid;
        logic [31:0]            pc;
        logic [31:0]            pc_next;
    } entry_t;

    entry_t     entry_q [2];
    entry_t     entry_d;
    logic       rd_ptr_q;
    logic       wr_ptr_q;
    logic [1:0] count_q;
    logic [1:0] count_d;
    logic       full_q;
    logic       ins_is16;
    logic       rvc;
    logic       push;
    logic       pop;

    always_comb begin
        ins_is16 = (pfu_ins_i[1:0] != 2'b11);
        rvc      = C_RVC_EN & ~pfu_ferr_i & ins_is16;
        // Reset gates the ack so the pre-fetch unit never sees an accept while held in reset.
        push     = resetb_i & clk_en_i & pfu_dav_i & ~full_q & ~exs_pc_wr_i;
        pop      = ids_valid_o & ids_ready_i & clk_en_i & ~exs_pc_wr_i;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};

        entry_d.ins     = rvc ? {16'b0, pfu_ins_i[15:0]} : pfu_ins_i;
        entry_d.rvc     = rvc;
        entry_d.ilgl    = ~C_RVC_EN & ~pfu_ferr_i & ins_is16;
        entry_d.ferr    = pfu_ferr_i;
        entry_d.sofid   = pfu_sofid_i;
        entry_d.pc      = pfu_pc_i;
        entry_d.pc_next = pfu_pc_i + (rvc ? 32'd2 : 32'd4);
    end

    assign pfu_ack_o      = push;
    assign pfu_ack_size_o = rvc ? 2'b01 : 2'b10;

    assign ids_valid_o    = (count_q != 2'd0);
    assign ids_ins_o      = entry_q[rd_ptr_q].ins;
    assign ids_rvc_o      = entry_q[rd_ptr_q].rvc;
    assign ids_ilgl_o     = entry_q[rd_ptr_q].ilgl;
    assign ids_ferr_o     = entry_q[rd_ptr_q].ferr;
    assign ids_sofid_o    = entry_q[rd_ptr_q].sofid;
    assign ids_pc_o       = entry_q[rd_ptr_q].pc;
    assign ids_pc_next_o  = entry_q[rd_ptr_q].pc_next;

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            full_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                entry_q[i] <= '0;
            end
        end else if (clk_en_i) begin
            if (exs_pc_wr_i) begin
                // Payload is left stale; an empty count keeps it invisible.
                count_q  <= 2'd0;
                rd_ptr_q <= 1'b0;
                wr_ptr_q <= 1'b0;
                full_q   <= 1'b0;
            end else begin
                if (push) begin
                    entry_q[wr_ptr_q] <= entry_d;
                    wr_ptr_q          <= ~wr_ptr_q;
                end
                if (pop) begin
                    rd_ptr_q <= ~rd_ptr_q;
                end
                count_q <= count_d;
                full_q  <= (count_d == 2'd2);
            end
        end
    end

endmodule
